// File: rtl/alu_resp_checker.sv
// Response checker for the 4-bit ALU. It recomputes each observed result through a
// one-stage pipeline, counts checks and mismatches, and latches the first failure.
module alu_resp_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_chk,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_s,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_y;
  logic [2:0]       s1_s;
  logic [CNT_W-1:0] s1_idx;
  logic             err_seen;
  logic             start_ok;
  logic             session_full;
  logic             accept;
  logic [WIDTH-1:0] exp_val;
  logic             mismatch;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = x + z;
      3'b001:  r = x - z;
      3'b010:  r = x & z;
      3'b011:  r = x | z;
      3'b100:  r = x ^ z;
      3'b101:  r = ~x;
      3'b110:  r = {x[WIDTH-2:0], 1'b0};
      default: r = {1'b0, x[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign start_ok     = start && ((state == IDLE) || (state == DONE));
  // Once every requested sample has been taken, RUN stops accepting and waits for the last compare
  assign session_full = (acc_cnt == num_reg);
  assign accept       = (state == RUN) && in_valid && !session_full;
  assign exp_val      = ref_alu(s1_s, s1_a, s1_b);
  assign mismatch     = s1_valid && (exp_val != s1_y);

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok) state_next = (num_chk == '0) ? DONE : RUN;
      RUN:        if (session_full) state_next = DRAIN;
      DRAIN:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_reg       <= '0;
      acc_cnt       <= '0;
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_y          <= '0;
      s1_s          <= '0;
      s1_idx        <= '0;
      err_seen      <= 1'b0;
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_s   <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (start_ok) begin
      num_reg       <= num_chk;
      acc_cnt       <= '0;
      s1_valid      <= 1'b0;
      err_seen      <= 1'b0;
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_s   <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_y    <= y;
        s1_s    <= s;
        s1_idx  <= acc_cnt;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (s1_valid && (chk_cnt != CNT_MAX)) chk_cnt <= chk_cnt + 1'b1;
      // Only the first mismatch of a session is captured; later ones just count
      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        if (!err_seen) begin
          err_seen      <= 1'b1;
          first_err_idx <= s1_idx;
          first_err_s   <= s1_s;
          first_err_exp <= exp_val;
          first_err_got <= s1_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_resp_checker.sv
// Bench for alu_resp_checker: a scoreboard queue holds each sample's expected compare
// outcome and is retired one edge after acceptance to build the reference counters.
module tb_alu_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] num_chk;
  logic [3:0] a, b, y;
  logic [2:0] s;
  logic       busy, done, pass;
  logic [7:0] chk_cnt, err_cnt, first_err_idx;
  logic [2:0] first_err_s;
  logic [3:0] first_err_exp, first_err_got;

  typedef struct {
    int         due;
    logic [7:0] idx;
    logic [2:0] s;
    logic [3:0] exp_v;
    logic [3:0] got;
  } item_t;

  item_t      sbq[$];
  int         cyc = 0;
  int         sent = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_chk, exp_err, exp_fidx;
  logic [2:0] exp_fs;
  logic [3:0] exp_fexp, exp_fgot;
  bit         seen;

  alu_resp_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_chk(num_chk), .in_valid(in_valid),
    .a(a), .b(b), .s(s), .y(y), .busy(busy), .done(done), .pass(pass),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_err_s(first_err_s), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] x, input logic [3:0] z);
    case (op)
      3'd0: return x + z;
      3'd1: return x - z;
      3'd2: return x & z;
      3'd3: return x | z;
      3'd4: return x ^ z;
      3'd5: return ~x;
      3'd6: return {x[2:0], 1'b0};
      default: return {1'b0, x[3:1]};
    endcase
  endfunction

  task automatic clear_model();
    exp_chk = 0; exp_err = 0; exp_fidx = 0; exp_fs = 0; exp_fexp = 0; exp_fgot = 0;
    seen = 0; sent = 0;
    sbq.delete();
  endtask

  // Advance one edge, then retire every scoreboard entry the DUT has compared by now
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      item_t it;
      it = sbq.pop_front();
      if (exp_chk != 8'hFF) exp_chk++;
      if (it.exp_v !== it.got) begin
        if (exp_err != 8'hFF) exp_err++;
        if (!seen) begin
          seen = 1; exp_fidx = it.idx; exp_fs = it.s; exp_fexp = it.exp_v; exp_fgot = it.got;
        end
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] x, input logic [3:0] z,
                      input logic [3:0] yy, input bit expect_acc);
    s = op; a = x; b = z; y = yy; in_valid = 1'b1;
    if (expect_acc) begin
      sbq.push_back('{due: cyc + 2, idx: sent[7:0], s: op, exp_v: ref_alu(op, x, z), got: yy});
      sent++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_session(input logic [7:0] n);
    start = 1'b1; num_chk = n;
    tick();
    start = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags got %b exp 000", {busy, done, pass}); end
    n_checks++; if ({chk_cnt, err_cnt} !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_counts got %h exp 0000", {chk_cnt, err_cnt}); end
    n_checks++; if ({first_err_idx, first_err_s, first_err_exp, first_err_got} !== 19'h0) begin
      n_fail++; $display("[TB] FAIL reset_first_err got %h exp 0", {first_err_idx, first_err_s, first_err_exp, first_err_got}); end
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) send(3'd0, 4'd1, 4'd1, 4'd7, 1'b0);
    tick();
    n_checks++; if (chk_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL idle_ignore chk_cnt got %0d exp 0", chk_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_correct();
    begin_session(8'd5);
    send(3'b000, 4'd5, 4'd9, 4'd14, 1'b1);
    send(3'b001, 4'd8, 4'd3, 4'd5, 1'b1);
    send(3'b010, 4'd6, 4'd2, 4'd2, 1'b1);
    send(3'b011, 4'd9, 4'd2, 4'd11, 1'b1);
    send(3'b100, 4'd6, 4'd4, 4'd2, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL correct_busy got %b exp 1", busy); end
    tick();
    n_checks++; if (chk_cnt !== exp_chk) begin n_fail++; $display("[TB] FAIL correct_chk got %0d exp %0d", chk_cnt, exp_chk); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL correct_done_early got %b exp 0", done); end
    tick();
    n_checks++; if ({done, pass, busy} !== 3'b110) begin n_fail++; $display("[TB] FAIL correct_done got %b exp 110", {done, pass, busy}); end
    n_checks++; if ({chk_cnt, err_cnt} !== {8'd5, 8'd0}) begin n_fail++; $display("[TB] FAIL correct_counts got %0d/%0d exp 5/0", chk_cnt, err_cnt); end
  endtask

  task automatic test_faults();
    begin_session(8'd3);
    send(3'b000, 4'd5, 4'd9, 4'd13, 1'b1);
    send(3'b111, 4'b1001, 4'd3, 4'b0100, 1'b1);
    send(3'b001, 4'd2, 4'd5, 4'b1101, 1'b1);
    tick(); tick();
    n_checks++; if (err_cnt !== exp_err) begin n_fail++; $display("[TB] FAIL faults_err got %0d exp %0d", err_cnt, exp_err); end
    n_checks++; if ({first_err_idx, first_err_s, first_err_exp, first_err_got} !== {exp_fidx, exp_fs, exp_fexp, exp_fgot}) begin
      n_fail++; $display("[TB] FAIL faults_first got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", first_err_idx, first_err_s,
                         first_err_exp, first_err_got, exp_fidx, exp_fs, exp_fexp, exp_fgot); end
    n_checks++; if ({done, pass} !== 2'b10) begin n_fail++; $display("[TB] FAIL faults_pass got %b exp 10", {done, pass}); end
  endtask

  task automatic test_zero_and_ignored_start();
    begin_session(8'd0);
    n_checks++; if ({done, pass, busy} !== 3'b110) begin n_fail++; $display("[TB] FAIL zero_len got %b exp 110", {done, pass, busy}); end
    begin_session(8'd3);
    send(3'b101, 4'd3, 4'd0, 4'd12, 1'b1);
    start = 1'b1; num_chk = 8'd1;
    tick();
    start = 1'b0;
    send(3'b110, 4'b0110, 4'd0, 4'b1100, 1'b1);
    send(3'b011, 4'd1, 4'd2, 4'd0, 1'b1);
    n_checks++; if (chk_cnt !== exp_chk) begin n_fail++; $display("[TB] FAIL ignstart_mid got %0d exp %0d", chk_cnt, exp_chk); end
    tick(); tick();
    n_checks++; if ({chk_cnt, err_cnt} !== {exp_chk, exp_err}) begin
      n_fail++; $display("[TB] FAIL ignstart_counts got %0d/%0d exp %0d/%0d", chk_cnt, err_cnt, exp_chk, exp_err); end
    n_checks++; if ({done, pass, first_err_idx} !== {1'b1, 1'b0, exp_fidx}) begin
      n_fail++; $display("[TB] FAIL ignstart_done got %b/%b/%0d exp 1/0/%0d", done, pass, first_err_idx, exp_fidx); end
  endtask

  task automatic test_reset_mid();
    begin_session(8'd4);
    send(3'b000, 4'd1, 4'd1, 4'd3, 1'b1);
    send(3'b010, 4'd3, 4'd5, 4'd1, 1'b1);
    tick();
    n_checks++; if (err_cnt !== exp_err) begin n_fail++; $display("[TB] FAIL rstmid_pre_err got %0d exp %0d", err_cnt, exp_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    n_checks++; if ({busy, done, pass, chk_cnt, err_cnt} !== 19'h0) begin
      n_fail++; $display("[TB] FAIL rstmid_outputs got %h exp 0", {busy, done, pass, chk_cnt, err_cnt}); end
    n_checks++; if ({first_err_idx, first_err_s, first_err_exp, first_err_got} !== 19'h0) begin
      n_fail++; $display("[TB] FAIL rstmid_first got %h exp 0", {first_err_idx, first_err_s, first_err_exp, first_err_got}); end
    begin_session(8'd1);
    send(3'b011, 4'd4, 4'd3, 4'd7, 1'b1);
    tick(); tick();
    n_checks++; if ({done, pass, err_cnt, chk_cnt} !== {2'b11, 8'd0, 8'd1}) begin
      n_fail++; $display("[TB] FAIL rstmid_new got %b%b/%0d/%0d exp 11/0/1", done, pass, err_cnt, chk_cnt); end
  endtask

  task automatic test_gapped();
    begin_session(8'd2);
    send(3'b100, 4'd3, 4'd5, 4'd6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_busy cycle %0d got %b exp 1", i, busy); end
    end
    send(3'b101, 4'd5, 4'd0, 4'd10, 1'b1);
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_done_early got %b exp 0", done); end
    tick();
    n_checks++; if ({done, pass, chk_cnt} !== {2'b11, 8'd2}) begin n_fail++; $display("[TB] FAIL gap_done got %b%b/%0d exp 11/2", done, pass, chk_cnt); end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [3:0] x, z, yy;
    begin_session(8'd24);
    send(3'b110, 4'b0110, 4'd9, 4'b1100, 1'b1);
    send(3'b001, 4'd2, 4'd5, 4'd13, 1'b1);
    for (int i = 0; i < 22; i++) begin
      op = 3'($urandom_range(0, 7)); x = 4'($urandom); z = 4'($urandom);
      yy = ref_alu(op, x, z);
      if ($urandom_range(0, 3) == 0) yy = yy ^ 4'($urandom_range(1, 15));
      send(op, x, z, yy, 1'b1);
      if ($urandom_range(0, 4) == 0) tick();
      n_checks++; if ({chk_cnt, err_cnt} !== {exp_chk, exp_err}) begin
        n_fail++; $display("[TB] FAIL random_counts step %0d got %0d/%0d exp %0d/%0d", i, chk_cnt, err_cnt, exp_chk, exp_err); end
    end
    tick(); tick();
    n_checks++; if ({first_err_idx, first_err_s, first_err_exp, first_err_got} !== {exp_fidx, exp_fs, exp_fexp, exp_fgot}) begin
      n_fail++; $display("[TB] FAIL random_first got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", first_err_idx, first_err_s,
                         first_err_exp, first_err_got, exp_fidx, exp_fs, exp_fexp, exp_fgot); end
    n_checks++; if ({done, pass} !== {1'b1, exp_err == 8'd0}) begin
      n_fail++; $display("[TB] FAIL random_done got %b%b exp 1%b", done, pass, exp_err == 8'd0); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_chk = 8'd0;
    a = 4'd0; b = 4'd0; s = 3'd0; y = 4'd0;
    clear_model();
    test_reset();
    test_correct();
    test_faults();
    test_zero_and_ignored_start();
    test_reset_mid();
    test_gapped();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_resp_checker.md
Name: alu_resp_checker

Overview:
Sequential response checker for the 4-bit ALU. It sits on the ALU output side and is the consuming end of the stimulus/response interface. It samples each presented (a, b, s, y) tuple, recomputes the expected result from the reference opcode map, and compares it with y. It counts checks and mismatches, captures the first failure, and reports pass/fail once a programmed number of samples has been checked.

Parameters:
WIDTH, 4, operand/result width (a, b, y)
CNT_W, 8, width of sample counters and index fields

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; opens a check session (accepted in IDLE or DONE only)
num_chk  input  CNT_W  number of samples in the session; sampled on accepted start
in_valid  input  1  tuple on a/b/s/y valid this cycle
a  input  WIDTH  operand A as applied to ALU
b  input  WIDTH  operand B as applied to ALU
s  input  3  opcode as applied to ALU
y  input  WIDTH  ALU result
busy  output  1  session active (RUN or DRAIN)
done  output  1  session complete; held until next accepted start or rst
pass  output  1  valid when done=1; 1 iff err_cnt==0
chk_cnt  output  CNT_W  samples compared so far
err_cnt  output  CNT_W  mismatches so far
first_err_idx  output  CNT_W  index (0-based) of first mismatching sample
first_err_s  output  3  opcode of first mismatch
first_err_exp  output  WIDTH  expected value at first mismatch
first_err_got  output  WIDTH  y value at first mismatch

Behaviour:
- Opcode map (all results mod 2^WIDTH):
  - 000 a+b; 001 a-b; 010 a&b; 011 a|b
  - 100 a^b; 101 ~a; 110 a<<1 (LSB 0); 111 a>>1 (MSB 0)
- Reset (rst=1 at an edge): state IDLE; all outputs 0, including done, pass and all first_err_* fields. Applies identically mid-session; the session is abandoned.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: load num_chk, clear counters, first_err_* and the first-error flag; done=0, pass=0.
    - num_chk!=0: go to RUN.
    - num_chk==0: go directly to DONE with pass=1.
  - RUN: each cycle with in_valid=1 accepts one sample into the stage-1 register (a, b, s, y, index = accepted count). When the accepted count reaches num_chk, go to DRAIN; further in_valid is ignored from that point.
  - DRAIN: one cycle; the last stage-1 sample is compared. Then go to DONE.
  - DONE: done=1, pass=(err_cnt==0). Stays until start or rst.
- start while in RUN/DRAIN is ignored. in_valid outside RUN is ignored.
- Pipeline: a sample accepted at edge k is compared at edge k+1. chk_cnt, err_cnt and first_err_* update at edge k+1. Back-to-back in_valid is supported at full rate with no stall. done rises at the edge after the last comparison.
- First mismatch: latched once per session. Later mismatches only increment err_cnt.
- chk_cnt and err_cnt saturate at 2^CNT_W-1 and never wrap.
- busy=1 exactly in RUN and DRAIN.

Test Plan:
- Reset/idle: rst for 2 cycles -> all outputs 0. in_valid pulses while IDLE -> chk_cnt stays 0.
- Correct ALU, 5 samples: start with num_chk=5. Feed (s=000,a=5,b=9,y=14), (001,8,3,5), (010,6,2,2), (011,9,2,11), (100,6,4,2) back-to-back -> chk_cnt=5, err_cnt=0, done=1, pass=1, done rising 2 edges after the last in_valid.
- Injected faults: num_chk=3. Feed (000,5,9,y=13), (111,4'b1001,x,y=4'b0100), (001,2,5,y=4'b1101) -> err_cnt=1, first_err_idx=0, first_err_s=000, first_err_exp=14, first_err_got=13, pass=0. Wrap-around cases (0110 shl->1100, 2-5->13) must count as correct.
- Zero-length and ignored start: start with num_chk=0 -> done=1, pass=1 next cycle. start pulsed mid-RUN -> counters unaffected.
- Reset mid-session: num_chk=4, after 2 samples (one mismatching) assert rst -> all outputs 0. New session with 1 correct sample -> pass=1, err_cnt=0.
- Gapped input: num_chk=2, in_valid on cycles 1 and 6 only -> busy held through the gap; done follows the second sample by 2 edges.
